// File: rtl/square_motion_sched_pkg.sv
// Shared types and constants for the bouncing-square motion scheduler.
package sq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UPD_X = 2'd1,
        UPD_Y = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int H_ACT   = 640;
    localparam int V_ACT   = 480;
    localparam int SQ_SIZE = 16;

    // Direction bit: 1 moves towards larger coordinates.
    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    // Squares start spread along a diagonal so they never overlap at power-up.
    function automatic int reset_x(input int i);
        return 32 + 64 * i;
    endfunction

    function automatic int reset_y(input int i);
        return 16 + 48 * i;
    endfunction

    function automatic logic reset_dir_x(input int i);
        return ((i % 2) == 0) ? DIR_POS : DIR_NEG;
    endfunction

    function automatic logic reset_dir_y(input int i);
        return (((i >> 1) & 1) == 0) ? DIR_POS : DIR_NEG;
    endfunction

endpackage

// File: rtl/square_motion_sched_axis_step.sv
// One-axis position step with clamp-and-bounce at 0 and at the far edge.
module sq_axis_step #(
    parameter int W = 11
) (
    input  logic [W-1:0] pos,
    input  logic         dir,
    input  logic [2:0]   speed,
    input  logic [W-1:0] max_pos,
    output logic [W-1:0] new_pos,
    output logic         new_dir,
    output logic         bounce
);
    import sq_pkg::*;

    logic [W-1:0] spd_ext;
    logic [W-1:0] sum;

    assign spd_ext = {{(W-3){1'b0}}, speed};
    // W has one bit of headroom over the coordinate, so pos+speed cannot wrap.
    assign sum     = pos + spd_ext;

    // Clamp to the edge and reverse when the step would reach or cross it.
    always_comb begin
        new_pos = pos;
        new_dir = dir;
        bounce  = 1'b0;
        if (dir == DIR_POS) begin
            if (sum >= max_pos) begin
                new_pos = max_pos;
                new_dir = DIR_NEG;
                bounce  = 1'b1;
            end else begin
                new_pos = sum;
            end
        end else begin
            // pos <= speed includes speed 0 at pos 0, which still flips.
            if (pos <= spd_ext) begin
                new_pos = '0;
                new_dir = DIR_POS;
                bounce  = 1'b1;
            end else begin
                new_pos = pos - spd_ext;
            end
        end
    end

endmodule

// File: rtl/square_motion_sched.sv
// Per-frame sweep over all squares, sharing one axis-step unit for x then y.
module square_motion_sched #(
    parameter int NUM_SQ  = 4,
    parameter int H_ACT   = sq_pkg::H_ACT,
    parameter int V_ACT   = sq_pkg::V_ACT,
    parameter int SQ_SIZE = sq_pkg::SQ_SIZE,
    parameter int XW      = 10,
    parameter int YW      = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      frame_tick,
    input  logic                      pause,
    input  logic [2:0]                speed,
    input  logic [$clog2(NUM_SQ)-1:0] rd_idx,
    output logic [XW-1:0]             rd_x,
    output logic [YW-1:0]             rd_y,
    output logic                      busy,
    output logic                      upd_done,
    output logic                      overrun,
    output logic [NUM_SQ-1:0]         bounce_flags
);
    import sq_pkg::*;

    localparam int IW    = $clog2(NUM_SQ);
    localparam int W     = XW + 1;
    localparam int X_MAX = H_ACT - SQ_SIZE;
    localparam int Y_MAX = V_ACT - SQ_SIZE;

    state_t                     state;
    logic [IW-1:0]              idx;
    logic [NUM_SQ-1:0][XW-1:0]  pos_x;
    logic [NUM_SQ-1:0][YW-1:0]  pos_y;
    logic [NUM_SQ-1:0]          dir_x;
    logic [NUM_SQ-1:0]          dir_y;

    logic [W-1:0] ax_pos, ax_max, ax_new;
    logic         ax_dir, ax_ndir, ax_bounce;
    logic         unused_hi;

    // Feed the shared step unit with the axis selected by the current state.
    always_comb begin
        ax_pos = {1'b0, pos_x[idx]};
        ax_dir = dir_x[idx];
        ax_max = W'(X_MAX);
        if (state == UPD_Y) begin
            ax_pos = {{(W-YW){1'b0}}, pos_y[idx]};
            ax_dir = dir_y[idx];
            ax_max = W'(Y_MAX);
        end
    end

    sq_axis_step #(.W(W)) u_step (
        .pos     (ax_pos),
        .dir     (ax_dir),
        .speed   (speed),
        .max_pos (ax_max),
        .new_pos (ax_new),
        .new_dir (ax_ndir),
        .bounce  (ax_bounce)
    );

    // Results never exceed MAX, so the headroom bit is always zero.
    assign unused_hi = ax_new[XW];

    // Sweep FSM: owns the square table and the status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            busy         <= 1'b0;
            upd_done     <= 1'b0;
            overrun      <= 1'b0;
            bounce_flags <= '0;
            for (int i = 0; i < NUM_SQ; i++) begin
                pos_x[i] <= XW'(reset_x(i));
                pos_y[i] <= YW'(reset_y(i));
                dir_x[i] <= reset_dir_x(i);
                dir_y[i] <= reset_dir_y(i);
            end
        end else begin
            upd_done <= 1'b0;
            // A tick that lands mid-sweep is dropped but reported.
            overrun  <= frame_tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_tick && ena && !pause) begin
                        state        <= UPD_X;
                        idx          <= '0;
                        bounce_flags <= '0;
                        busy         <= 1'b1;
                    end
                end
                UPD_X: begin
                    pos_x[idx] <= ax_new[XW-1:0];
                    dir_x[idx] <= ax_ndir;
                    if (ax_bounce) bounce_flags[idx] <= 1'b1;
                    state <= UPD_Y;
                end
                UPD_Y: begin
                    pos_y[idx] <= ax_new[YW-1:0];
                    dir_y[idx] <= ax_ndir;
                    if (ax_bounce) bounce_flags[idx] <= 1'b1;
                    if (idx == IW'(NUM_SQ - 1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        upd_done <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= UPD_X;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered renderer read port; out-of-range indices read as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_x <= '0;
            rd_y <= '0;
        end else if (int'(rd_idx) < NUM_SQ) begin
            rd_x <= pos_x[rd_idx];
            rd_y <= pos_y[rd_idx];
        end else begin
            rd_x <= '0;
            rd_y <= '0;
        end
    end

endmodule
